data_mem_access_sequencer: RTL and testbench

Multi-cycle load/store sequencer between the processor's memory stage and the word-organised data memory. Accepts byte, halfword and word accesses at any byte address and issues aligned word accesses with byte enables to the data memory. An access that crosses a word boundary is split into two word accesses. Loads are returned sign- or zero-extended. The core stalls on `req_ready` low.

---
 rtl/data_mem_access_sequencer.sv | 173 +++++++++++++++++
 tb/tb_data_mem_access_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_access_sequencer.sv
// Load/store sequencer: turns byte/half/word accesses at any byte address into
// one or two aligned word accesses with byte enables, and extends load data.
module data_mem_access_sequencer #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // Handshake: a request is taken on the rising edge where req_valid & req_ready;
  // req_ready is high only in IDLE, and resp_valid is a single-cycle completion pulse.
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-3:0] mem_addr,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  output logic [1:0]            dbg_state_o
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACC0 = 2'd1, S_ACC1 = 2'd2, S_CAP = 2'd3} state_e;

  state_e                state_q, state_d;
  logic                  we_q, uns_q;
  logic [1:0]            size_q, off_q;
  logic [31:0]           wdata_q, lo_q;
  logic [ADDR_WIDTH-3:0] word_a_q;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_err_q, resp_err_d;
  logic [31:0]           resp_rdata_q, resp_rdata_d;

  logic                  accept;
  logic [2:0]            nbytes;
  logic                  split;
  logic [7:0]            mask;
  logic [63:0]           wdata_sh;
  logic [63:0]           word64;
  logic [31:0]           ld_word, ld_ext;

  assign req_ready   = (state_q == S_IDLE);
  assign accept      = req_valid & req_ready;
  assign resp_valid  = resp_valid_q;
  assign resp_err    = resp_err_q;
  assign resp_rdata  = resp_rdata_q;
  assign dbg_state_o = state_q;

  // Everything below works only from latched request fields, never from req_*.
  always_comb begin
    nbytes = 3'd0;
    mask   = 8'h00;
    case (size_q)
      2'b00:   begin nbytes = 3'd1; mask = 8'h01; end
      2'b01:   begin nbytes = 3'd2; mask = 8'h03; end
      2'b10:   begin nbytes = 3'd4; mask = 8'h0f; end
      default: begin nbytes = 3'd0; mask = 8'h00; end
    endcase
    mask     = mask << off_q;
    split    = ({1'b0, off_q} + nbytes) > 3'd4;
    wdata_sh = {32'b0, wdata_q} << {off_q, 3'b000};
    word64   = split ? {mem_rdata, lo_q} : {32'b0, mem_rdata};
    ld_word  = 32'(word64 >> {off_q, 3'b000});
    ld_ext   = 32'b0;
    case (size_q)
      2'b00:   ld_ext = uns_q ? {24'b0, ld_word[7:0]}  : {{24{ld_word[7]}}, ld_word[7:0]};
      2'b01:   ld_ext = uns_q ? {16'b0, ld_word[15:0]} : {{16{ld_word[15]}}, ld_word[15:0]};
      2'b10:   ld_ext = ld_word;
      default: ld_ext = 32'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && req_size != 2'b11) state_d = S_ACC0;
      S_ACC0:  state_d = split ? S_ACC1 : (we_q ? S_IDLE : S_CAP);
      S_ACC1:  state_d = we_q ? S_IDLE : S_CAP;
      S_CAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_addr     = word_a_q;
    mem_re       = 1'b0;
    mem_we       = 1'b0;
    mem_be       = 4'b0000;
    mem_wdata    = wdata_sh[31:0];
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = resp_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (accept && req_size == 2'b11) begin
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_rdata_d = 32'b0;
        end
      end
      S_ACC0: begin
        if (we_q) begin
          mem_we = 1'b1;
          mem_be = mask[3:0];
          if (!split) begin
            resp_valid_d = 1'b1;
            resp_rdata_d = 32'b0;
          end
        end else begin
          mem_re = 1'b1;
        end
      end
      S_ACC1: begin
        mem_addr  = word_a_q + (ADDR_WIDTH-2)'(1);
        mem_wdata = wdata_sh[63:32];
        if (we_q) begin
          mem_we       = 1'b1;
          mem_be       = mask[7:4];
          resp_valid_d = 1'b1;
          resp_rdata_d = 32'b0;
        end else begin
          mem_re = 1'b1;
        end
      end
      S_CAP: begin
        resp_valid_d = 1'b1;
        resp_rdata_d = ld_ext;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      size_q       <= 2'b00;
      off_q        <= 2'b00;
      wdata_q      <= 32'b0;
      word_a_q     <= '0;
      lo_q         <= 32'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'b0;
    end else begin
      if (accept) begin
        we_q     <= req_we;
        uns_q    <= req_unsigned;
        size_q   <= req_size;
        off_q    <= req_addr[1:0];
        wdata_q  <= req_wdata;
        word_a_q <= req_addr[ADDR_WIDTH-1:2];
      end
      // In ACC1 of a load, mem_rdata carries the word-A data read in ACC0.
      if (state_q == S_ACC1 && !we_q) lo_q <= mem_rdata;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

endmodule

// File: tb/tb_data_mem_access_sequencer.sv
// Bench for data_mem_access_sequencer: word memory device, byte-level reference
// model, and queued expectations for responses, memory writes and memory reads.
module tb_data_mem_access_sequencer;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [29:0] mem_addr;
  logic        mem_re, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata, mem_rdata_r;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [64:0] exp_q[$];  // {err, rdata, response cycle}
  logic [65:0] wr_q[$];   // {word, be, lane data}
  logic [29:0] rd_q[$];

  logic [31:0] dmem[logic [29:0]];
  logic [7:0]  rmem[logic [31:0]];

  data_mem_access_sequencer #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input logic [29:0] i);
    return ({2'b0, i} * 32'h9e3779b9) ^ 32'h5a5a5a5a;
  endfunction

  function automatic logic [31:0] dget(input logic [29:0] i);
    if (dmem.exists(i)) return dmem[i];
    return init_word(i);
  endfunction

  // memory device
  logic [31:0] wtmp;
  assign mem_rdata = mem_rdata_r;
  initial mem_rdata_r = 32'b0;
  always @(posedge clk) begin
    if (mem_we) begin
      wtmp = dget(mem_addr);
      for (int i = 0; i < 4; i++) if (mem_be[i]) wtmp[8*i +: 8] = mem_wdata[8*i +: 8];
      dmem[mem_addr] = wtmp;
    end
    if (mem_re) mem_rdata_r <= dget(mem_addr);
  end

  // reference model: byte-addressed little-endian memory
  function automatic logic [7:0] rbyte(input logic [31:0] a);
    logic [31:0] w;
    if (rmem.exists(a)) return rmem[a];
    w = init_word(a[31:2]);
    return w[{a[1:0], 3'b000} +: 8];
  endfunction

  function automatic int nbytes_of(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] s, input logic u);
    logic [31:0] v;
    int n;
    n = nbytes_of(s);
    v = 32'b0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = rbyte(a + 32'(i));
    if (!u && n < 4 && v[8*n-1]) for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hff;
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] a, input int n, input logic [31:0] wd);
    logic [29:0] w0, w1;
    logic [3:0]  be0, be1;
    logic [31:0] d0, d1, b;
    w0 = a[31:2]; w1 = w0; be0 = 4'b0; be1 = 4'b0; d0 = 32'b0; d1 = 32'b0;
    for (int i = 0; i < n; i++) begin
      b = a + 32'(i);
      if (b[31:2] == w0) begin
        be0[b[1:0]] = 1'b1;
        d0[{b[1:0], 3'b000} +: 8] = wd[8*i +: 8];
      end else begin
        w1 = b[31:2];
        be1[b[1:0]] = 1'b1;
        d1[{b[1:0], 3'b000} +: 8] = wd[8*i +: 8];
      end
      rmem[b] = wd[8*i +: 8];
    end
    wr_q.push_back({w0, be0, d0});
    if (be1 != 4'b0) wr_q.push_back({w1, be1, d1});
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] need);
    total++;
    if (got !== need) begin
      bad++;
      $display("FAIL %s: got %08h need %08h", nm, got, need);
    end
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({nm, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({nm, "_resp_err"}, 32'(resp_err), 32'd0);
    chk({nm, "_resp_rdata"}, resp_rdata, 32'd0);
    chk({nm, "_mem_we_re_be"}, {26'b0, mem_we, mem_re, mem_be}, 32'd0);
    chk({nm, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  // driver: called just after a rising edge; returns just after the accept edge
  task automatic do_req(input logic we, input logic [31:0] a, input logic [1:0] s,
                        input logic u, input logic [31:0] wd, input logic use_c,
                        input logic [31:0] cval, output int acc);
    int n, lat, waited;
    logic [31:0] rd;
    logic [29:0] wlast;
    req_we = we; req_addr = a; req_size = s; req_unsigned = u; req_wdata = wd;
    req_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout: req_ready stayed %0b, need 1", req_ready);
      req_valid = 1'b0;
      acc = -1;
      @(posedge clk); #1;
      return;
    end
    acc = cyc;
    rd = 32'b0;
    if (s == 2'b11) begin
      exp_q.push_back({1'b1, 32'b0, 32'(acc + 1)});
    end else begin
      n = nbytes_of(s);
      wlast = 30'((a + 32'(n - 1)) >> 2);
      if (we) begin
        ref_store(a, n, wd);
        lat = (wlast != a[31:2]) ? 3 : 2;
      end else begin
        rd_q.push_back(a[31:2]);
        if (wlast != a[31:2]) rd_q.push_back(wlast);
        rd = use_c ? cval : ref_load(a, s, u);
        lat = (wlast != a[31:2]) ? 4 : 3;
      end
      exp_q.push_back({1'b0, rd, 32'(acc + lat)});
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr = $urandom; req_wdata = $urandom; req_we = 1'($urandom);
    req_size = 2'($urandom); req_unsigned = 1'($urandom);
  endtask

  // monitor / scoreboard
  logic [64:0] e_r;
  logic [65:0] e_w;
  logic [29:0] e_a;
  always @(negedge clk) begin
    if (rst_n) begin
      if (resp_valid) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL resp_unexpected: got err=%0b rdata=%08h at cycle %0d, need no response", resp_err, resp_rdata, cyc);
        end else begin
          e_r = exp_q.pop_front();
          if ({resp_err, resp_rdata} !== e_r[64:32] || 32'(cyc) !== e_r[31:0]) begin
            bad++;
            $display("FAIL resp: got err=%0b rdata=%08h cycle=%0d, need err=%0b rdata=%08h cycle=%0d",
                     resp_err, resp_rdata, cyc, e_r[64], e_r[63:32], e_r[31:0]);
          end
        end
      end
      if (mem_we) begin
        total++;
        if (wr_q.size() == 0) begin
          bad++;
          $display("FAIL mem_write_unexpected: got addr=%08h be=%04b, need no write", mem_addr, mem_be);
        end else begin
          e_w = wr_q.pop_front();
          if (mem_re || mem_addr !== e_w[65:36] || mem_be !== e_w[35:32] ||
              (mem_wdata & {{8{mem_be[3]}}, {8{mem_be[2]}}, {8{mem_be[1]}}, {8{mem_be[0]}}}) !== e_w[31:0]) begin
            bad++;
            $display("FAIL mem_write: got addr=%08h be=%04b data=%08h re=%0b, need addr=%08h be=%04b data=%08h re=0",
                     mem_addr, mem_be, mem_wdata, mem_re, e_w[65:36], e_w[35:32], e_w[31:0]);
          end
        end
      end else if (mem_re) begin
        total++;
        if (rd_q.size() == 0) begin
          bad++;
          $display("FAIL mem_read_unexpected: got addr=%08h, need no read", mem_addr);
        end else begin
          e_a = rd_q.pop_front();
          if (mem_addr !== e_a || mem_be !== 4'b0) begin
            bad++;
            $display("FAIL mem_read: got addr=%08h be=%04b, need addr=%08h be=0000", mem_addr, mem_be, e_a);
          end
        end
      end else begin
        total++;
        if (mem_be !== 4'b0) begin
          bad++;
          $display("FAIL idle_be: got %04b need 0000", mem_be);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at time %0t, need completion", $time);
    $fatal(1, "watchdog expired");
  end

  // stimulus
  initial begin
    int t0, t1, g;
    logic [31:0] a, pw, pv, saved9;
    logic [1:0]  s;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'b0;
    req_size = 2'b00; req_unsigned = 1'b0; req_wdata = 32'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_req(1'b1, 32'h16, 2'b01, 1'b0, 32'h0000_0f0f, 1'b0, 32'b0, t0);
    do_req(1'b1, 32'h13, 2'b10, 1'b0, 32'h1122_3344, 1'b0, 32'b0, t0);
    repeat (4) @(posedge clk); #1;

    pw = 32'haabb_ccdd; pv = 32'h1122_3344;
    dmem[30'd4] = pw; dmem[30'd5] = pv;
    for (int i = 0; i < 4; i++) begin
      rmem[32'h10 + 32'(i)] = pw[8*i +: 8];
      rmem[32'h14 + 32'(i)] = pv[8*i +: 8];
    end
    do_req(1'b0, 32'h13, 2'b10, 1'b0, 32'b0, 1'b1, 32'h2233_44aa, t0);
    do_req(1'b0, 32'h13, 2'b01, 1'b0, 32'b0, 1'b1, 32'h0000_44aa, t0);
    do_req(1'b0, 32'h12, 2'b00, 1'b0, 32'b0, 1'b1, 32'hffff_ffbb, t0);
    do_req(1'b0, 32'h12, 2'b00, 1'b1, 32'b0, 1'b1, 32'h0000_00bb, t0);
    repeat (5) @(posedge clk); #1;

    do_req(1'b0, 32'h40, 2'b11, 1'b0, 32'b0, 1'b0, 32'b0, t0);
    do_req(1'b0, 32'h10, 2'b10, 1'b0, 32'b0, 1'b0, 32'b0, t1);
    chk("b2b_accept_cycle", 32'(t1), 32'(t0 + 1));

    do_req(1'b1, 32'hffff_ffff, 2'b01, 1'b0, 32'h0000_beef, 1'b0, 32'b0, t0);
    do_req(1'b0, 32'hffff_ffff, 2'b01, 1'b0, 32'b0, 1'b1, 32'hffff_beef, t0);
    repeat (6) @(posedge clk); #1;

    // reset during ACC0 of a split word store (words 8 and 9)
    saved9 = dget(30'd9);
    do_req(1'b1, 32'h21, 2'b10, 1'b0, 32'hcafe_f00d, 1'b0, 32'b0, t0);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals("midreset");
    repeat (2) @(negedge clk);
    chk("midreset_word_b_untouched", dget(30'd9), saved9);
    exp_q.delete(); wr_q.delete(); rd_q.delete();
    for (int i = 0; i < 8; i++) begin
      a = 32'h20 + 32'(i);
      pw = dget(a[31:2]);
      rmem[a] = pw[{a[1:0], 3'b000} +: 8];
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 300; k++) begin
      g = $urandom_range(0, 15);
      s = (g == 0) ? 2'b11 : 2'(g % 3);
      if ($urandom_range(0, 7) == 0) a = 32'hffff_fffc + 32'($urandom_range(0, 3));
      else a = 32'($urandom_range(0, 63));
      do_req(1'($urandom), a, s, 1'($urandom), $urandom, 1'b0, 32'b0, t0);
      g = $urandom_range(0, 2);
      if (g > 0) begin
        repeat (g) @(posedge clk);
        #1;
      end
    end
    repeat (8) @(posedge clk); #1;

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
    chk("rd_q_drained", 32'(rd_q.size()), 32'd0);
    foreach (rmem[ra]) begin
      pw = dget(ra[31:2]);
      chk("final_mem_byte", {24'b0, pw[{ra[1:0], 3'b000} +: 8]}, {24'b0, rmem[ra]});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
